// File: rtl/ttt_pkg.sv
// Shared constants and types for the tic-tac-toe move arbiter.
// Status encoding matches the game engine's eng_game_status output.
package ttt_pkg;

    localparam logic [1:0] ST_DRAW  = 2'b00;
    localparam logic [1:0] ST_A_WIN = 2'b01;
    localparam logic [1:0] ST_B_WIN = 2'b10;
    localparam logic [1:0] ST_RUN   = 2'b11;

    localparam logic PLAYER_A = 1'b1;
    localparam logic PLAYER_B = 1'b0;

    localparam int BOARD_CELLS = 9;

    typedef enum logic [2:0] {
        CLEAR,
        WAIT_MOVE,
        ISSUE,
        SETTLE,
        DONE
    } arb_state_t;

    // Result when the turn holder forfeits: the other player wins.
    function automatic logic [1:0] opponent_wins(input logic turn);
        return (turn == PLAYER_A) ? ST_B_WIN : ST_A_WIN;
    endfunction

endpackage

// File: rtl/ttt_move_arbiter_if.sv
// Player move port: level request with cell, one-cycle ack/nack reply.
// master = player side, slave = arbiter side.
interface ttt_move_arbiter_if;

    logic       req;
    logic [3:0] pos;
    logic       ack;
    logic       nack;

    modport master (
        output req,
        output pos,
        input  ack,
        input  nack
    );

    modport slave (
        input  req,
        input  pos,
        output ack,
        output nack
    );

endinterface

// File: rtl/ttt_turn_timer.sv
// Per-turn cycle counter; expired flags the last allowed cycle.
// Saturates at the counter's maximum value instead of wrapping.
module ttt_turn_timer #(
    parameter int TURN_TIMEOUT = 1000,
    parameter int CNT_W        = $clog2(TURN_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TURN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/ttt_move_arbiter.sv
// Shares one tic-tac-toe engine between two player ports: turn
// arbitration, cell pre-check, status readback, timeout and restart.
module ttt_move_arbiter
    import ttt_pkg::*;
#(
    parameter int TURN_TIMEOUT = 1000,
    parameter int CNT_W        = $clog2(TURN_TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    ttt_move_arbiter_if.slave  a_port,
    ttt_move_arbiter_if.slave  b_port,
    input  logic               new_game,
    output logic               eng_reset,
    output logic [3:0]         eng_position,
    output logic               eng_player_select,
    input  logic               eng_current_turn,
    input  logic [1:0]         eng_game_status,
    output logic [1:0]         result,
    output logic               forfeit
);

    arb_state_t             state;
    logic [BOARD_CELLS-1:0] occ;

    logic a_ack_q;
    logic a_nack_q;
    logic b_ack_q;
    logic b_nack_q;

    logic       a_live;
    logic       b_live;
    logic       a_turn;
    logic       sel_req;
    logic [3:0] sel_pos;
    logic       sel_ok;
    logic       accept;
    logic       a_rej;
    logic       b_rej;

    logic timer_run;
    logic timer_expired;

    assign a_port.ack  = a_ack_q;
    assign a_port.nack = a_nack_q;
    assign b_port.ack  = b_ack_q;
    assign b_port.nack = b_nack_q;

    // A port's request is blanked while its own reply is on the wire.
    always_comb begin
        a_live  = a_port.req & ~(a_ack_q | a_nack_q);
        b_live  = b_port.req & ~(b_ack_q | b_nack_q);
        a_turn  = (eng_current_turn == PLAYER_A);
        sel_req = a_turn ? a_live : b_live;
        sel_pos = a_turn ? a_port.pos : b_port.pos;
        sel_ok  = (sel_pos < 4'(BOARD_CELLS)) && !occ[sel_pos];
        accept  = sel_req && sel_ok;
        a_rej   = a_live && !(a_turn && sel_ok);
        b_rej   = b_live && !(!a_turn && sel_ok);
    end

    assign timer_run = (state == WAIT_MOVE);

    ttt_turn_timer #(
        .TURN_TIMEOUT (TURN_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!timer_run),
        .run     (timer_run),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= CLEAR;
            occ               <= '0;
            eng_reset         <= 1'b1;
            eng_position      <= '0;
            eng_player_select <= 1'b0;
            result            <= ST_RUN;
            forfeit           <= 1'b0;
            a_ack_q           <= 1'b0;
            a_nack_q          <= 1'b0;
            b_ack_q           <= 1'b0;
            b_nack_q          <= 1'b0;
        end else begin
            a_ack_q           <= 1'b0;
            a_nack_q          <= 1'b0;
            b_ack_q           <= 1'b0;
            b_nack_q          <= 1'b0;
            eng_reset         <= 1'b0;
            eng_player_select <= ~eng_current_turn;

            if (new_game) begin
                state     <= CLEAR;
                eng_reset <= 1'b1;
            end else begin
                unique case (state)
                    CLEAR: begin
                        occ     <= '0;
                        result  <= ST_RUN;
                        forfeit <= 1'b0;
                        // Engine comes out of reset with A to move.
                        eng_player_select <= ~PLAYER_A;
                        state   <= WAIT_MOVE;
                    end
                    WAIT_MOVE: begin
                        a_nack_q <= a_rej;
                        b_nack_q <= b_rej;
                        if (accept) begin
                            a_ack_q           <= a_turn;
                            b_ack_q           <= ~a_turn;
                            occ[sel_pos]      <= 1'b1;
                            eng_position      <= sel_pos;
                            eng_player_select <= eng_current_turn;
                            state             <= ISSUE;
                        end else if (timer_expired) begin
                            result  <= opponent_wins(eng_current_turn);
                            forfeit <= 1'b1;
                            state   <= DONE;
                        end
                    end
                    ISSUE: begin
                        // The engine turn flips at the end of this
                        // cycle; keeping the mover selected makes the
                        // select differ from the new turn in SETTLE.
                        eng_player_select <= eng_player_select;
                        state             <= SETTLE;
                    end
                    SETTLE: begin
                        if (eng_game_status == ST_RUN) begin
                            state <= WAIT_MOVE;
                        end else begin
                            result <= eng_game_status;
                            state  <= DONE;
                        end
                    end
                    DONE: begin
                        a_nack_q <= a_live;
                        b_nack_q <= b_live;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ttt_move_arbiter.sv
// Scoreboarded bench for ttt_move_arbiter with a behavioural engine.
// Expected replies are queued per port and checked as they appear.
module tb_ttt_move_arbiter;
    import ttt_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       new_game = 1'b0;
    logic       eng_reset;
    logic [3:0] eng_position;
    logic       eng_player_select;
    logic       eng_current_turn;
    logic [1:0] eng_game_status;
    logic [1:0] result;
    logic       forfeit;

    ttt_move_arbiter_if a_if ();
    ttt_move_arbiter_if b_if ();

    int tests_run = 0;
    int n_fail = 0;
    bit qa[$];
    bit qb[$];

    // Engine model: ba/bb are the cells held by A and B.
    logic [8:0] ba = '0;
    logic [8:0] bb = '0;
    logic       turn = PLAYER_A;

    always #5 clk = ~clk;

    ttt_move_arbiter #(.TURN_TIMEOUT(TO)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .a_port            (a_if),
        .b_port            (b_if),
        .new_game          (new_game),
        .eng_reset         (eng_reset),
        .eng_position      (eng_position),
        .eng_player_select (eng_player_select),
        .eng_current_turn  (eng_current_turn),
        .eng_game_status   (eng_game_status),
        .result            (result),
        .forfeit           (forfeit)
    );

    function automatic logic [1:0] engine_status(
        input logic [8:0] xa,
        input logic [8:0] xb
    );
        logic [8:0] lines [8] = '{
            9'b000000111, 9'b000111000, 9'b111000000,
            9'b001001001, 9'b010010010, 9'b100100100,
            9'b100010001, 9'b001010100
        };
        for (int i = 0; i < 8; i++) begin
            if ((xa & lines[i]) == lines[i]) return ST_A_WIN;
            if ((xb & lines[i]) == lines[i]) return ST_B_WIN;
        end
        if ((xa | xb) == 9'h1FF) return ST_DRAW;
        return ST_RUN;
    endfunction

    assign eng_game_status  = engine_status(ba, bb);
    assign eng_current_turn = turn;

    always @(posedge clk) begin
        if (eng_reset) begin
            ba   <= '0;
            bb   <= '0;
            turn <= PLAYER_A;
        end else if (eng_game_status == ST_RUN
                     && eng_player_select == turn
                     && eng_position < 4'd9
                     && !ba[eng_position] && !bb[eng_position]) begin
            if (turn == PLAYER_A) ba[eng_position] <= 1'b1;
            else                  bb[eng_position] <= 1'b1;
            turn <= ~turn;
        end
    end

    // Reply monitor: every ack/nack must match the queued expectation.
    always @(negedge clk) begin
        bit e;
        if (reset_n && (a_if.ack || a_if.nack)) begin
            tests_run++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL a_reply: ack=%b nack=%b, none expected",
                         a_if.ack, a_if.nack);
            end else begin
                e = qa.pop_front();
                if (a_if.ack !== e || a_if.nack !== !e) begin
                    n_fail++;
                    $display("FAIL a_reply: ack=%b nack=%b, want ack=%b",
                             a_if.ack, a_if.nack, e);
                end
            end
        end
        if (reset_n && (b_if.ack || b_if.nack)) begin
            tests_run++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL b_reply: ack=%b nack=%b, none expected",
                         b_if.ack, b_if.nack);
            end else begin
                e = qb.pop_front();
                if (b_if.ack !== e || b_if.nack !== !e) begin
                    n_fail++;
                    $display("FAIL b_reply: ack=%b nack=%b, want ack=%b",
                             b_if.ack, b_if.nack, e);
                end
            end
        end
    end

    // Drive one request and wait (bounded) for its reply.
    task automatic play(input bit is_a, input logic [3:0] pos,
                        input bit exp_ack, output int lat);
        bit got;
        if (is_a) qa.push_back(exp_ack);
        else      qb.push_back(exp_ack);
        @(negedge clk);
        if (is_a) begin a_if.req = 1'b1; a_if.pos = pos; end
        else      begin b_if.req = 1'b1; b_if.pos = pos; end
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk);
            #1;
            got = is_a ? (a_if.ack | a_if.nack) : (b_if.ack | b_if.nack);
            if (got) lat = i;
        end
        if (is_a) a_if.req = 1'b0;
        else      b_if.req = 1'b0;
        if (!got) begin
            tests_run++;
            n_fail++;
            $display("FAIL reply_timeout: port=%s pos=%0d no reply, want one",
                     is_a ? "A" : "B", pos);
            if (is_a && qa.size() > 0) void'(qa.pop_back());
            if (!is_a && qb.size() > 0) void'(qb.pop_back());
        end
    endtask

    task automatic start_game();
        @(posedge clk);
        #1 new_game = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (eng_reset !== 1'b1 || result !== ST_RUN || forfeit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: eng_reset=%b result=%b forfeit=%b, want 1 11 0",
                     eng_reset, result, forfeit);
        end
        tests_run++;
        if ({a_if.ack, a_if.nack, b_if.ack, b_if.nack} !== 4'b0
            || eng_position !== 4'd0 || eng_player_select !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: replies=%b pos=%0d sel=%b, want 0",
                     {a_if.ack, a_if.nack, b_if.ack, b_if.nack},
                     eng_position, eng_player_select);
        end
        reset_n = 1'b1;
        tests_run++;
        if (eng_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_cycle: eng_reset=%b, want 1", eng_reset);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (eng_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_once: eng_reset=%b, want 0", eng_reset);
        end
    endtask

    task automatic test_alternating();
        int lat;
        play(1, 4'd0, 1, lat);
        play(0, 4'd3, 1, lat);
        play(1, 4'd1, 1, lat);
        play(0, 4'd4, 1, lat);
        play(1, 4'd2, 1, lat);
        @(posedge clk);
        #1;
        tests_run++;
        if (result !== ST_RUN) begin
            n_fail++;
            $display("FAIL alt_settle: result=%b, want 11", result);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (result !== ST_A_WIN || forfeit !== 1'b0) begin
            n_fail++;
            $display("FAIL alt_result: result=%b forfeit=%b, want 01 0",
                     result, forfeit);
        end
    endtask

    task automatic test_out_of_turn();
        int lat;
        start_game();
        play(0, 4'd4, 0, lat);
        tests_run++;
        if (lat != 1 || eng_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL oot_nack: latency=%0d eng_reset=%b, want 1 0",
                     lat, eng_reset);
        end
        play(1, 4'd4, 1, lat);
        tests_run++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL oot_ack_latency: got %0d, want 1", lat);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (ba[4] !== 1'b1 || bb[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL oot_board: a4=%b b4=%b, want 1 0", ba[4], bb[4]);
        end
    endtask

    task automatic test_bad_cells();
        int lat;
        start_game();
        play(1, 4'd0, 1, lat);
        play(0, 4'd0, 0, lat);
        play(0, 4'd9, 0, lat);
        play(0, 4'd8, 1, lat);
        @(posedge clk);
        #1;
        tests_run++;
        if (bb !== 9'h100 || ba !== 9'h001) begin
            n_fail++;
            $display("FAIL bad_board: a=%b b=%b, want 000000001 100000000",
                     ba, bb);
        end
    endtask

    task automatic test_full_board();
        int lat;
        logic [3:0] seq [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3,
                                4'd5, 4'd7, 4'd6, 4'd8};
        start_game();
        for (int i = 0; i < 9; i++) play(i % 2 == 0, seq[i], 1, lat);
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (result !== ST_DRAW || forfeit !== 1'b0) begin
            n_fail++;
            $display("FAIL draw_result: result=%b forfeit=%b, want 00 0",
                     result, forfeit);
        end
        play(1, 4'd5, 0, lat);
        play(0, 4'd2, 0, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        start_game();
        qa.push_back(1'b1);
        qb.push_back(1'b0);
        @(negedge clk);
        a_if.req = 1'b1;
        a_if.pos = 4'd4;
        b_if.req = 1'b1;
        b_if.pos = 4'd5;
        @(posedge clk);
        #1;
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        tests_run++;
        if (a_if.ack !== 1'b1 || b_if.nack !== 1'b1) begin
            n_fail++;
            $display("FAIL both_req: a_ack=%b b_nack=%b, want 1 1",
                     a_if.ack, b_if.nack);
        end
        play(0, 4'd5, 1, lat);
        tests_run++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL next_move_latency: got %0d, want 3", lat);
        end
    endtask

    task automatic test_timeout();
        int lat;
        @(posedge clk);
        #1 new_game = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
        tests_run++;
        if (eng_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL ng_eng_reset: got %b, want 1", eng_reset);
        end
        @(posedge clk);
        #1;
        repeat (TO - 1) @(posedge clk);
        #1;
        tests_run++;
        if (result !== ST_RUN || forfeit !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: result=%b forfeit=%b, want 11 0",
                     result, forfeit);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (result !== ST_B_WIN || forfeit !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_result: result=%b forfeit=%b, want 10 1",
                     result, forfeit);
        end
        play(0, 4'd0, 0, lat);
        tests_run++;
        if (result !== ST_B_WIN || forfeit !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_hold: result=%b forfeit=%b, want 10 1",
                     result, forfeit);
        end
    endtask

    task automatic test_restart_issue();
        int lat;
        start_game();
        play(1, 4'd0, 1, lat);
        new_game = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
        tests_run++;
        if (eng_reset !== 1'b1 || a_if.ack !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clear: eng_reset=%b a_ack=%b, want 1 0",
                     eng_reset, a_if.ack);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (result !== ST_RUN || eng_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_state: result=%b eng_reset=%b, want 11 0",
                     result, eng_reset);
        end
        play(1, 4'd0, 1, lat);
    endtask

    task automatic test_async_reset();
        int lat;
        start_game();
        play(1, 4'd5, 1, lat);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (eng_reset !== 1'b1 || eng_position !== 4'd0
            || eng_player_select !== 1'b0 || result !== ST_RUN
            || forfeit !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: rst=%b pos=%0d sel=%b res=%b ff=%b, want 1 0 0 11 0",
                     eng_reset, eng_position, eng_player_select,
                     result, forfeit);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        play(1, 4'd5, 1, lat);
        tests_run++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL post_reset_move: latency=%0d, want 1", lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        a_if.req = 1'b0;
        a_if.pos = 4'd0;
        b_if.req = 1'b0;
        b_if.pos = 4'd0;
        test_reset();
        test_alternating();
        test_out_of_turn();
        test_bad_cells();
        test_full_board();
        test_back_to_back();
        test_timeout();
        test_restart_issue();
        test_async_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL pending_replies: a=%0d b=%0d, want 0 0",
                     qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
        $finish;
    end

endmodule
